// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared state encoding and port indices for the data memory arbiter.
package dm_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;
endpackage

// File: rtl/arb_select_2.sv
// arb_select_2: two-way grant selection; on conflict the port not granted last wins.
module arb_select_2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);
    assign win_o = (&req_i) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one Data_Memory between core (port 0) and debug/loader (port 1).
// Define DATA_MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [DATA_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic [1:0]            gnt_q, gnt_d, rvalid_q, rvalid_d, win;
    logic                  rd_q, rd_d, wr_q, wr_d, ptr;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign ptr = last_q;
`else
    assign ptr = 1'b1;
`endif

    arb_select_2 u_sel (.req_i({req1_i, req0_i}), .last_i(ptr), .win_o(win));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        port_d   = port_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: if (|win) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                port_d  = win[PORT_DBG];
                gnt_d   = win;
                wr_d    = win[PORT_DBG] ? we1_i : we0_i;
                rd_d    = !wr_d;
                addr_d  = win[PORT_DBG] ? addr1_i : addr0_i;
                wdata_d = win[PORT_DBG] ? wdata1_i : wdata0_i;
`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
                last_d  = win[PORT_DBG];
`endif
            end
            // strobes and bus values double as the latched request
            ACCESS: if (cnt_q == 4'd0) begin
                state_d  = DONE;
                rdata_d  = rd_q ? mem_rdata_i : rdata_q;
                rd_d     = 1'b0;
                wr_d     = 1'b0;
                addr_d   = '0;
                wdata_d  = '0;
                rvalid_d = port_q ? 2'b10 : 2'b01;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            port_q   <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign gnt0_o      = gnt_q[PORT_CORE];
    assign gnt1_o      = gnt_q[PORT_DBG];
    assign rvalid0_o   = rvalid_q[PORT_CORE];
    assign rvalid1_o   = rvalid_q[PORT_DBG];
    assign rdata_o     = rdata_q;
    assign mem_read_o  = rd_q;
    assign mem_write_o = wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of data_mem_arbiter with WAIT_STATES=1 and a WAIT_STATES=0 twin.
module tb_data_mem_arbiter;
    logic        clk, reset, req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic        gnt0, gnt1, rv0, rv1, mrd, mwr, busy;
    logic [31:0] rdata, maddr, mwdata;
    logic        gnt0_z, gnt1_z, rv0_z, rv1_z, mrd_z, mwr_z, busy_z;
    logic [31:0] rdata_z, maddr_z, mwdata_z;
    int          total = 0, bad = 0;

    data_mem_arbiter #(.DATA_WIDTH(32), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rv0), .rvalid1_o(rv1), .rdata_o(rdata),
        .mem_read_o(mrd), .mem_write_o(mwr), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    data_mem_arbiter #(.DATA_WIDTH(32), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset(reset), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0_z), .gnt1_o(gnt1_z), .rvalid0_o(rv0_z), .rvalid1_o(rv1_z), .rdata_o(rdata_z),
        .mem_read_o(mrd_z), .mem_write_o(mwr_z), .mem_addr_o(maddr_z), .mem_wdata_o(mwdata_z),
        .mem_rdata_i(mem_rdata), .busy_o(busy_z)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        reset = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 32'hCAFE0001;
        tick; tick;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("rst_rvalid", {30'd0, rv1, rv0}, 0);
        chk("rst_strobes", {30'd0, mrd, mwr}, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1;
        tick;
        chk("idle_busy", {31'd0, busy}, 0);

        // port 0 load at 0x10
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick;
        chk("ld_gnt0_c1", {30'd0, gnt1, gnt0}, 2'b01);
        chk("ld_rd_c1", {30'd0, mrd, mwr}, 2'b10);
        chk("ld_addr_c1", maddr, 32'h10);
        req0 = 0;
        tick;
        chk("ld_gnt_c2", {30'd0, gnt1, gnt0}, 0);
        chk("ld_rd_c2", {30'd0, mrd, mwr}, 2'b10);
        tick;
        chk("ld_rv_c3", {30'd0, rv1, rv0}, 2'b01);
        chk("ld_rdata_c3", rdata, 32'hCAFE0001);
        chk("ld_rd_c3", {30'd0, mrd, mwr}, 0);
        tick;
        chk("ld_rv_c4", {30'd0, rv1, rv0}, 0);
        chk("ld_busy_c4", {31'd0, busy}, 0);

        // port 1 store of 0x55 at 0x20
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55;
        tick;
        chk("st_gnt1_c1", {30'd0, gnt1, gnt0}, 2'b10);
        chk("st_wr_c1", {30'd0, mrd, mwr}, 2'b01);
        chk("st_addr_c1", maddr, 32'h20);
        chk("st_wdata_c1", mwdata, 32'h55);
        req1 = 0; addr1 = 32'hFF; wdata1 = 32'hEE;
        tick;
        chk("st_wr_c2", {30'd0, mrd, mwr}, 2'b01);
        chk("st_addr_c2", maddr, 32'h20);
        tick;
        chk("st_wr_c3", {30'd0, mrd, mwr}, 0);
        chk("st_rv_c3", {30'd0, rv1, rv0}, 2'b10);
        chk("st_rdata_hold", rdata, 32'hCAFE0001);
        tick;

        // both ports request continuously
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h100; addr1 = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick;
`ifdef DATA_MEM_ARBITER_ROUND_ROBIN_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("both_gnt%0d", k), {30'd0, gnt1, gnt0}, {30'd0, exp_g});
            chk($sformatf("both_addr%0d", k), maddr, exp_g[1] ? 32'h200 : 32'h100);
            tick; tick;
            chk($sformatf("both_busy_done%0d", k), {31'd0, busy}, 1);
            tick;
            chk($sformatf("both_gap%0d", k), {31'd0, busy}, 0);
        end
        req0 = 0; req1 = 0;
        tick; tick;
        chk("both_drained", {31'd0, busy}, 0);

        // reset on the second ACCESS cycle
        req0 = 1; we0 = 0; addr0 = 32'h30;
        tick;
        chk("ra_gnt0", {30'd0, gnt1, gnt0}, 2'b01);
        req0 = 0;
        tick;
        chk("ra_rd_c2", {30'd0, mrd, mwr}, 2'b10);
        reset = 0;
        tick;
        chk("ra_busy", {31'd0, busy}, 0);
        chk("ra_strobes", {30'd0, mrd, mwr}, 0);
        chk("ra_rvalid", {30'd0, rv1, rv0}, 0);
        chk("ra_rdata", rdata, 0);
        reset = 1;
        tick;
        chk("ra_rvalid_after", {30'd0, rv1, rv0}, 0);
        mem_rdata = 32'h12345678;
        req1 = 1; we1 = 0; addr1 = 32'h40;
        tick;
        chk("ra_new_gnt1", {30'd0, gnt1, gnt0}, 2'b10);
        req1 = 0;
        tick; tick;
        chk("ra_new_rv1", {30'd0, rv1, rv0}, 2'b10);
        chk("ra_new_rdata", rdata, 32'h12345678);
        tick; tick; tick;

        // zero wait states on the twin instance
        mem_rdata = 32'hA5A5A5A5;
        req0 = 1; we0 = 0; addr0 = 32'h50;
        tick;
        chk("ws0_gnt0", {31'd0, gnt0_z}, 1);
        chk("ws0_rd_c1", {30'd0, mrd_z, mwr_z}, 2'b10);
        req0 = 0;
        tick;
        chk("ws0_rv_c2", {30'd0, rv1_z, rv0_z}, 2'b01);
        chk("ws0_rdata_c2", rdata_z, 32'hA5A5A5A5);
        chk("ws0_rd_c2", {30'd0, mrd_z, mwr_z}, 0);
        chk("ws1_rv_c2", {31'd0, rv0}, 0);
        tick;
        chk("ws1_rv_c3", {31'd0, rv0}, 1);
        tick; tick;

        // req1 pulse during port 0 access is ignored
        req0 = 1; we0 = 0; addr0 = 32'h60;
        tick;
        chk("pl_gnt0", {30'd0, gnt1, gnt0}, 2'b01);
        req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h70;
        tick;
        req1 = 0;
        chk("pl_gnt1_c2", {31'd0, gnt1}, 0);
        chk("pl_strobes_c2", {30'd0, mrd, mwr}, 2'b10);
        tick;
        chk("pl_rv0_c3", {30'd0, rv1, rv0}, 2'b01);
        tick;
        chk("pl_idle_c4", {30'd0, busy, gnt1}, 0);
        tick;
        chk("pl_idle_c5", {29'd0, busy, gnt1, mwr}, 0);
        chk("pl_rv1_c5", {31'd0, rv1}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
